// File: rtl/lsu_ctrl_if.sv
// Handshake and RAM bus bundle for lsu_ctrl: request from execute,
// response to writeback, and the data RAM access port.
interface lsu_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_fault;

  logic        ram_wr_en;
  logic        ram_rd_en;
  logic [31:0] ram_addr;
  logic [2:0]  ram_rw_type;
  logic [31:0] ram_dat_i;
  logic [31:0] ram_dat_o;

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata, req_rd,
    input  resp_ready, ram_dat_o,
    output req_ready,
    output resp_valid, resp_rdata, resp_rd, resp_fault,
    output ram_wr_en, ram_rd_en, ram_addr,
    output ram_rw_type, ram_dat_i
  );

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata, req_rd,
    output resp_ready, ram_dat_o,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_rd, resp_fault,
    input  ram_wr_en, ram_rd_en, ram_addr,
    input  ram_rw_type, ram_dat_i
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store control: validates requests, runs one RAM access, returns
// a registered result. Ports: clk, rst_n, bus (lsu_ctrl_if.slave).
// Optional macro LSU_MISALIGN_SPLIT_EN: misaligned loads use two word reads.
module lsu_ctrl #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input logic       clk,
  input logic       rst_n,
  lsu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
`ifdef LSU_MISALIGN_SPLIT_EN
    , ACCESS_HI = 2'd3
`endif
  } state_e;

  state_e      state_q;
  logic        resp_valid_q;
  logic        resp_fault_q;
  logic [31:0] resp_rdata_q;
  logic [4:0]  resp_rd_q;
  logic        ram_wr_en_q;
  logic        ram_rd_en_q;
  logic [31:0] ram_addr_q;
  logic [2:0]  ram_rw_type_q;
  logic [31:0] ram_dat_i_q;

  logic        illegal;
  logic        mis;
  logic        mis_fault;
  logic        oor;
  logic        fault;
  logic        split;
  logic [32:0] span;
  logic [32:0] last_b;

  // Request check, evaluated on the raw request while in IDLE
  always_comb begin
    illegal = (bus.req_funct3 == 3'b011) ||
              (bus.req_funct3 == 3'b110) ||
              (bus.req_funct3 == 3'b111) ||
              (bus.req_we && bus.req_funct3[2]);
    mis = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
          ((bus.req_funct3[1:0] == 2'b10) &&
           (bus.req_addr[1:0] != 2'b00));
    unique case (bus.req_funct3[1:0])
      2'b00:   span = 33'd0;
      2'b01:   span = 33'd1;
      default: span = 33'd3;
    endcase
    // 33-bit sum so addresses near 2^32 cannot wrap into range
    last_b = {1'b0, bus.req_addr} + span;
    oor    = last_b >= 33'(MEM_BYTES);
`ifdef LSU_MISALIGN_SPLIT_EN
    split     = mis && !bus.req_we && !illegal;
    mis_fault = mis && bus.req_we;
`else
    split     = 1'b0;
    mis_fault = mis;
`endif
    fault = illegal || mis_fault || oor;
  end

`ifdef LSU_MISALIGN_SPLIT_EN
  logic        split_q;
  logic [1:0]  ofs_q;
  logic [2:0]  f3_q;
  logic [31:0] lo_q;
  logic [31:0] win;
  logic [31:0] split_res;

  // hi word arrives on ram_dat_o during ACCESS_HI
  always_comb begin
    win = 32'({bus.ram_dat_o, lo_q} >> {ofs_q, 3'b000});
    split_res = win;
    case (f3_q)
      3'b000:  split_res = {{24{win[7]}}, win[7:0]};
      3'b001:  split_res = {{16{win[15]}}, win[15:0]};
      3'b100:  split_res = {24'd0, win[7:0]};
      3'b101:  split_res = {16'd0, win[15:0]};
      default: split_res = win;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      resp_valid_q  <= 1'b0;
      resp_fault_q  <= 1'b0;
      resp_rdata_q  <= 32'd0;
      resp_rd_q     <= 5'd0;
      ram_wr_en_q   <= 1'b0;
      ram_rd_en_q   <= 1'b0;
      ram_addr_q    <= 32'd0;
      ram_rw_type_q <= 3'd0;
      ram_dat_i_q   <= 32'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
      split_q       <= 1'b0;
      ofs_q         <= 2'd0;
      f3_q          <= 3'd0;
      lo_q          <= 32'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            resp_rd_q    <= bus.req_rd;
            resp_rdata_q <= 32'd0;
            resp_fault_q <= fault;
            if (fault) begin
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              ram_wr_en_q   <= bus.req_we;
              ram_rd_en_q   <= !bus.req_we;
              ram_addr_q    <= bus.req_addr;
              ram_rw_type_q <= bus.req_funct3;
              ram_dat_i_q   <= bus.req_wdata;
              state_q       <= ACCESS;
`ifdef LSU_MISALIGN_SPLIT_EN
              split_q <= split;
              ofs_q   <= bus.req_addr[1:0];
              f3_q    <= bus.req_funct3;
              if (split) begin
                ram_addr_q    <= {bus.req_addr[31:2], 2'b00};
                ram_rw_type_q <= 3'b010;
              end
`endif
            end
          end
        end
        ACCESS: begin
          ram_wr_en_q <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
          if (split_q) begin
            lo_q       <= bus.ram_dat_o;
            ram_addr_q <= ram_addr_q + 32'd4;
            state_q    <= ACCESS_HI;
          end else
`endif
          begin
            ram_rd_en_q <= 1'b0;
            if (ram_rd_en_q) begin
              resp_rdata_q <= bus.ram_dat_o;
            end
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end
        end
`ifdef LSU_MISALIGN_SPLIT_EN
        ACCESS_HI: begin
          ram_rd_en_q  <= 1'b0;
          resp_rdata_q <= split_res;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
`endif
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_rd     = resp_rd_q;
  assign bus.resp_fault  = resp_fault_q;
  assign bus.ram_wr_en   = ram_wr_en_q;
  assign bus.ram_rd_en   = ram_rd_en_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_rw_type = ram_rw_type_q;
  assign bus.ram_dat_i   = ram_dat_i_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: byte-array RAM model plus a queue of expected
// responses pushed at request time and popped at response time.
module tb_lsu_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_ctrl_if bus();

  lsu_ctrl #(.MEM_BYTES(1024)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ef;
    int          lat;
  } op_t;

  localparam int OK  = 2;
  localparam int FLT = 1;
`ifdef LSU_MISALIGN_SPLIT_EN
  localparam int SPL = 3;
`endif

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   wr_cnt = 0;

  logic [7:0] mem [0:1023] = '{default: 8'h00};

  logic [9:0] ra;
  logic [7:0] b0, b1, b2, b3;
  always_comb begin
    ra = bus.ram_addr[9:0];
    b0 = mem[ra];
    b1 = mem[ra + 10'd1];
    b2 = mem[ra + 10'd2];
    b3 = mem[ra + 10'd3];
    bus.ram_dat_o = 32'd0;
    case (bus.ram_rw_type)
      3'b000: bus.ram_dat_o = {{24{b0[7]}}, b0};
      3'b001: bus.ram_dat_o = {{16{b1[7]}}, b1, b0};
      3'b010: bus.ram_dat_o = {b3, b2, b1, b0};
      3'b100: bus.ram_dat_o = {24'd0, b0};
      3'b101: bus.ram_dat_o = {16'd0, b1, b0};
      default: bus.ram_dat_o = 32'd0;
    endcase
  end

  logic [9:0] wa;
  assign wa = bus.ram_addr[9:0];
  always @(posedge clk) begin
    if (bus.ram_wr_en) begin
      wr_cnt <= wr_cnt + 1;
      case (bus.ram_rw_type)
        3'b000: mem[wa] <= bus.ram_dat_i[7:0];
        3'b001: begin
          mem[wa]         <= bus.ram_dat_i[7:0];
          mem[wa + 10'd1] <= bus.ram_dat_i[15:8];
        end
        3'b010: begin
          mem[wa]         <= bus.ram_dat_i[7:0];
          mem[wa + 10'd1] <= bus.ram_dat_i[15:8];
          mem[wa + 10'd2] <= bus.ram_dat_i[23:16];
          mem[wa + 10'd3] <= bus.ram_dat_i[31:24];
        end
        default: ;
      endcase
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] er,
                       input logic ef, input int lat);
    exp_t e;
    int n;
    e.rdata = er; e.fault = ef; e.rd = rd; e.lat = lat;
    sb.push_back(e);
    bus.req_we = we; bus.req_funct3 = f3; bus.req_addr = a;
    bus.req_wdata = wd; bus.req_rd = rd; bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.req_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: req_ready=%b want 1", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!bus.resp_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    if (!bus.resp_valid) begin
      total++; bad++;
      $display("FAIL resp_timeout: resp_valid=%b want 1", bus.resp_valid);
    end
  endtask

  task automatic ack();
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 ||
        bus.resp_fault !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: ready=%b valid=%b fault=%b want 1 0 0",
               bus.req_ready, bus.resp_valid, bus.resp_fault);
    end
    total++;
    if (bus.resp_rdata !== 32'd0 || bus.resp_rd !== 5'd0) begin
      bad++;
      $display("FAIL reset_resp: rdata=%h rd=%0d want 0 0",
               bus.resp_rdata, bus.resp_rd);
    end
    total++;
    if (bus.ram_wr_en !== 1'b0 || bus.ram_rd_en !== 1'b0 ||
        bus.ram_addr !== 32'd0 || bus.ram_rw_type !== 3'd0 ||
        bus.ram_dat_i !== 32'd0) begin
      bad++;
      $display("FAIL reset_ram: we=%b re=%b a=%h t=%0d d=%h want all 0",
               bus.ram_wr_en, bus.ram_rd_en, bus.ram_addr,
               bus.ram_rw_type, bus.ram_dat_i);
    end
  endtask

  task automatic test_store_load();
    op_t ops[11];
    exp_t e;
    int lat, w0;
    ops = '{
      '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, OK},
      '{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, OK},
      '{1'b1, 3'b010, 32'h20, 32'h80FF7F01, 32'h0, 1'b0, OK},
      '{1'b0, 3'b000, 32'h21, 32'h0, 32'h0000007F, 1'b0, OK},
      '{1'b0, 3'b000, 32'h23, 32'h0, 32'hFFFFFF80, 1'b0, OK},
      '{1'b0, 3'b101, 32'h22, 32'h0, 32'h000080FF, 1'b0, OK},
      '{1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF80FF, 1'b0, OK},
      '{1'b0, 3'b100, 32'h23, 32'h0, 32'h00000080, 1'b0, OK},
      '{1'b1, 3'b000, 32'h30, 32'h123456AA, 32'h0, 1'b0, OK},
      '{1'b1, 3'b001, 32'h32, 32'h9876BBCC, 32'h0, 1'b0, OK},
      '{1'b0, 3'b010, 32'h30, 32'h0, 32'hBBCC00AA, 1'b0, OK}
    };
    for (int i = 0; i < 11; i++) begin
      w0 = wr_cnt;
      issue(ops[i].we, ops[i].f3, ops[i].a, ops[i].wd, 5'(i + 1),
            ops[i].er, ops[i].ef, ops[i].lat);
      wait_resp(lat);
      e = sb.pop_front();
      total++;
      if (bus.resp_rdata !== e.rdata || bus.resp_fault !== e.fault ||
          bus.resp_rd !== e.rd || lat != e.lat) begin
        bad++;
        $display("FAIL ldst[%0d]: rdata=%h flt=%b rd=%0d lat=%0d want %h %b %0d %0d",
                 i, bus.resp_rdata, bus.resp_fault, bus.resp_rd, lat,
                 e.rdata, e.fault, e.rd, e.lat);
      end
      ack();
      total++;
      if (wr_cnt - w0 != ((ops[i].we && !ops[i].ef) ? 1 : 0)) begin
        bad++;
        $display("FAIL ldst_wr[%0d]: writes=%0d want %0d", i,
                 wr_cnt - w0, (ops[i].we && !ops[i].ef) ? 1 : 0);
      end
    end
  endtask

  task automatic test_fault();
    op_t ops[6];
    exp_t e;
    int lat, w0;
    ops = '{
      '{1'b1, 3'b001, 32'h13, 32'h00005555, 32'h0, 1'b1, FLT},
      '{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, OK},
      '{1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, FLT},
      '{1'b1, 3'b100, 32'h10, 32'h11111111, 32'h0, 1'b1, FLT},
      '{1'b0, 3'b111, 32'h10, 32'h0, 32'h0, 1'b1, FLT},
      '{1'b1, 3'b010, 32'h16, 32'h22222222, 32'h0, 1'b1, FLT}
    };
    for (int i = 0; i < 6; i++) begin
      w0 = wr_cnt;
      issue(ops[i].we, ops[i].f3, ops[i].a, ops[i].wd, 5'(i + 12),
            ops[i].er, ops[i].ef, ops[i].lat);
      wait_resp(lat);
      e = sb.pop_front();
      total++;
      if (bus.resp_rdata !== e.rdata || bus.resp_fault !== e.fault ||
          bus.resp_rd !== e.rd || lat != e.lat) begin
        bad++;
        $display("FAIL fault[%0d]: rdata=%h flt=%b rd=%0d lat=%0d want %h %b %0d %0d",
                 i, bus.resp_rdata, bus.resp_fault, bus.resp_rd, lat,
                 e.rdata, e.fault, e.rd, e.lat);
      end
      ack();
      total++;
      if (wr_cnt - w0 != ((ops[i].we && !ops[i].ef) ? 1 : 0)) begin
        bad++;
        $display("FAIL fault_wr[%0d]: writes=%0d want %0d", i,
                 wr_cnt - w0, (ops[i].we && !ops[i].ef) ? 1 : 0);
      end
    end
  endtask

  task automatic test_range();
    op_t ops[9];
    exp_t e;
    int lat, w0;
    ops = '{
      '{1'b1, 3'b010, 32'h3FC, 32'h11223344, 32'h0, 1'b0, OK},
      '{1'b0, 3'b010, 32'h3FC, 32'h0, 32'h11223344, 1'b0, OK},
      '{1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, FLT},
      '{1'b0, 3'b000, 32'h3FF, 32'h0, 32'h00000011, 1'b0, OK},
      '{1'b0, 3'b101, 32'h3FE, 32'h0, 32'h00001122, 1'b0, OK},
      '{1'b1, 3'b010, 32'h400, 32'h5A5A5A5A, 32'h0, 1'b1, FLT},
      '{1'b1, 3'b000, 32'h400, 32'h000000A5, 32'h0, 1'b1, FLT},
      '{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0, 32'h0, 1'b1, FLT},
      '{1'b0, 3'b100, 32'h3FF, 32'h0, 32'h00000011, 1'b0, OK}
    };
    for (int i = 0; i < 9; i++) begin
      w0 = wr_cnt;
      issue(ops[i].we, ops[i].f3, ops[i].a, ops[i].wd, 5'(i + 20),
            ops[i].er, ops[i].ef, ops[i].lat);
      wait_resp(lat);
      e = sb.pop_front();
      total++;
      if (bus.resp_rdata !== e.rdata || bus.resp_fault !== e.fault ||
          bus.resp_rd !== e.rd || lat != e.lat) begin
        bad++;
        $display("FAIL range[%0d]: rdata=%h flt=%b rd=%0d lat=%0d want %h %b %0d %0d",
                 i, bus.resp_rdata, bus.resp_fault, bus.resp_rd, lat,
                 e.rdata, e.fault, e.rd, e.lat);
      end
      ack();
      total++;
      if (wr_cnt - w0 != ((ops[i].we && !ops[i].ef) ? 1 : 0)) begin
        bad++;
        $display("FAIL range_wr[%0d]: writes=%0d want %0d", i,
                 wr_cnt - w0, (ops[i].we && !ops[i].ef) ? 1 : 0);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int lat;
    issue(1'b0, 3'b010, 32'h10, 32'h0, 5'd9, 32'hDEADBEEF, 1'b0, OK);
    wait_resp(lat);
    e = sb.pop_front();
    bus.req_we = 1'b0; bus.req_funct3 = 3'b010;
    bus.req_addr = 32'h20; bus.req_rd = 5'd30; bus.req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== e.rdata ||
          bus.resp_rd !== e.rd || bus.resp_fault !== e.fault ||
          bus.req_ready !== 1'b0) begin
        bad++;
        $display("FAIL hold[%0d]: v=%b rdata=%h rd=%0d flt=%b rdy=%b want 1 %h %0d %b 0",
                 c, bus.resp_valid, bus.resp_rdata, bus.resp_rd,
                 bus.resp_fault, bus.req_ready, e.rdata, e.rd, e.fault);
      end
    end
    bus.req_valid = 1'b0;
    ack();
    total++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL hold_release: v=%b rdy=%b want 0 1",
               bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int lat, w0;
    w0 = wr_cnt;
    bus.req_we = 1'b1; bus.req_funct3 = 3'b010; bus.req_addr = 32'h40;
    bus.req_wdata = 32'hCAFEF00D; bus.req_rd = 5'd4; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    total++;
    if (bus.ram_wr_en !== 1'b1) begin
      bad++;
      $display("FAIL mid_access: wr_en=%b want 1", bus.ram_wr_en);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (bus.ram_wr_en !== 1'b0 || bus.ram_rd_en !== 1'b0 ||
        bus.ram_addr !== 32'd0 || bus.ram_dat_i !== 32'd0 ||
        bus.resp_valid !== 1'b0 || bus.resp_rd !== 5'd0) begin
      bad++;
      $display("FAIL mid_reset: we=%b re=%b a=%h d=%h v=%b rd=%0d want all 0",
               bus.ram_wr_en, bus.ram_rd_en, bus.ram_addr,
               bus.ram_dat_i, bus.resp_valid, bus.resp_rd);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (wr_cnt != w0 || bus.req_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_nowrite: writes=%0d rdy=%b want 0 1",
               wr_cnt - w0, bus.req_ready);
    end
    issue(1'b0, 3'b010, 32'h40, 32'h0, 5'd6, 32'h0, 1'b0, OK);
    wait_resp(lat);
    e = sb.pop_front();
    total++;
    if (bus.resp_rdata !== e.rdata || bus.resp_fault !== e.fault ||
        bus.resp_rd !== e.rd || lat != e.lat) begin
      bad++;
      $display("FAIL mid_load: rdata=%h flt=%b rd=%0d lat=%0d want %h %b %0d %0d",
               bus.resp_rdata, bus.resp_fault, bus.resp_rd, lat,
               e.rdata, e.fault, e.rd, e.lat);
    end
    ack();
  endtask

  task automatic test_split();
    op_t ops[6];
    exp_t e;
    int lat, w0;
    ops = '{
      '{1'b1, 3'b010, 32'h0, 32'h44332211, 32'h0, 1'b0, OK},
      '{1'b1, 3'b010, 32'h4, 32'h88776655, 32'h0, 1'b0, OK},
`ifdef LSU_MISALIGN_SPLIT_EN
      '{1'b0, 3'b010, 32'h2, 32'h0, 32'h66554433, 1'b0, SPL},
      '{1'b0, 3'b001, 32'h3, 32'h0, 32'h00005544, 1'b0, SPL},
`else
      '{1'b0, 3'b010, 32'h2, 32'h0, 32'h0, 1'b1, FLT},
      '{1'b0, 3'b001, 32'h3, 32'h0, 32'h0, 1'b1, FLT},
`endif
      '{1'b1, 3'b010, 32'h2, 32'hFFFFFFFF, 32'h0, 1'b1, FLT},
      '{1'b0, 3'b010, 32'h3FE, 32'h0, 32'h0, 1'b1, FLT}
    };
    for (int i = 0; i < 6; i++) begin
      w0 = wr_cnt;
      issue(ops[i].we, ops[i].f3, ops[i].a, ops[i].wd, 5'(i + 3),
            ops[i].er, ops[i].ef, ops[i].lat);
      wait_resp(lat);
      e = sb.pop_front();
      total++;
      if (bus.resp_rdata !== e.rdata || bus.resp_fault !== e.fault ||
          bus.resp_rd !== e.rd || lat != e.lat) begin
        bad++;
        $display("FAIL split[%0d]: rdata=%h flt=%b rd=%0d lat=%0d want %h %b %0d %0d",
                 i, bus.resp_rdata, bus.resp_fault, bus.resp_rd, lat,
                 e.rdata, e.fault, e.rd, e.lat);
      end
      ack();
      total++;
      if (wr_cnt - w0 != ((ops[i].we && !ops[i].ef) ? 1 : 0)) begin
        bad++;
        $display("FAIL split_wr[%0d]: writes=%0d want %0d", i,
                 wr_cnt - w0, (ops[i].we && !ops[i].ef) ? 1 : 0);
      end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.req_rd = 5'd0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_store_load();
    test_fault();
    test_range();
    test_backpressure();
    test_reset_mid();
    test_split();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
